// File: rtl/sipo_capture_if.sv
// Serial-in / parallel-out capture bus: serial producer side plus held-word consumer side.
// The master modport is the environment; the slave modport is the capture block.
interface sipo_capture_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CntW = $clog2(WIDTH);

  logic              din;
  logic              shift_en;
  logic              dout_ready;
  logic [WIDTH-1:0]  dout;
  logic              dout_valid;
  logic [CntW-1:0]   bit_cnt;
  logic              overrun;

  modport master (
    output din,
    output shift_en,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  bit_cnt,
    input  overrun
  );

  modport slave (
    input  din,
    input  shift_en,
    input  dout_ready,
    output dout,
    output dout_valid,
    output bit_cnt,
    output overrun
  );
endinterface

// File: rtl/sipo_capture.sv
// MSB-first serial word assembler with a one-entry holding register, valid/ready handoff
// and a sticky overrun flag for words completed while the holding register is occupied.
module sipo_capture #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          Re,
  input  logic          inz,
  sipo_capture_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic {StEmpty, StFull} hold_e;

  hold_e            state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             consume;

  assign word     = {shift_q[WIDTH-2:0], bus.din};
  assign complete = bus.shift_en && (cnt_q == CntW'(WIDTH - 1));
  assign consume  = (state_q == StFull) && bus.dout_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    if (inz) begin
      state_d = StEmpty;
      shift_d = '0;
      dout_d  = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      if (bus.shift_en) begin
        shift_d = word;
        cnt_d   = complete ? '0 : cnt_q + 1'b1;
      end
      unique case (state_q)
        StEmpty: begin
          if (complete) begin
            dout_d  = word;
            state_d = StFull;
          end
        end
        StFull: begin
          // A completion without a same-cycle consume drops the new word.
          if (complete && consume) begin
            dout_d = word;
          end else if (complete) begin
            ovr_d = 1'b1;
          end else if (consume) begin
            state_d = StEmpty;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Re) begin
      state_q <= StEmpty;
      shift_q <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = (state_q == StFull);
  assign bus.bit_cnt    = cnt_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_sipo_capture.sv
// Self-checking bench for sipo_capture: directed scenarios plus a scoreboard that checks
// every word the holding register presents against the words the stimulus expects to land.
module tb_sipo_capture;
  logic clk;
  logic Re;
  logic inz;

  sipo_capture_if #(.WIDTH(8)) bus ();

  sipo_capture #(.WIDTH(8)) dut (
    .clk (clk),
    .Re  (Re),
    .inz (inz),
    .bus (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift one byte MSB-first; optionally idle between bits and raise ready on the final bit.
  task automatic shift_word(input logic [7:0] w, input bit gapped, input bit push,
                            input bit ready_last);
    if (push) sb_q.push_back(w);
    for (int i = 7; i >= 0; i--) begin
      bus.din      = w[i];
      bus.shift_en = 1'b1;
      if (i == 0 && ready_last) bus.dout_ready = 1'b1;
      tick();
      bus.dout_ready = 1'b0;
      if (gapped) begin
        bus.shift_en = 1'b0;
        bus.din      = ~w[i];
        tick();
        check_eq("gap_hold_cnt", 32'(bus.bit_cnt), 32'((8 - i) % 8));
      end
    end
    bus.shift_en = 1'b0;
  endtask

  task automatic consume_one();
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [7:0] d, input logic v,
                             input logic [2:0] c, input logic o);
    check_eq({tag, "_dout"},  32'(bus.dout),       32'(d));
    check_eq({tag, "_valid"}, 32'(bus.dout_valid), 32'(v));
    check_eq({tag, "_cnt"},   32'(bus.bit_cnt),    32'(c));
    check_eq({tag, "_ovr"},   32'(bus.overrun),    32'(o));
  endtask

  // Scoreboard monitor: a word is new when valid rises or follows a consumed word.
  logic prev_valid = 1'b0;
  logic prev_take  = 1'b0;
  always @(negedge clk) begin
    logic [31:0] exp;
    if (bus.dout_valid === 1'b1 && (!prev_valid || prev_take)) begin
      exp = 32'hxxxx_xxxx;
      if (sb_q.size() > 0) exp = 32'(sb_q.pop_front());
      check_eq("sb_word", 32'(bus.dout), exp);
    end
    prev_valid = (bus.dout_valid === 1'b1);
    prev_take  = (bus.dout_valid === 1'b1) && (bus.dout_ready === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    Re             = 1'b0;
    inz            = 1'b0;
    bus.din        = 1'b0;
    bus.shift_en   = 1'b0;
    bus.dout_ready = 1'b0;
    tick();
    check_state("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    Re = 1'b1;

    // Basic continuous capture.
    shift_word(8'hA5, 1'b0, 1'b1, 1'b0);
    check_state("basic", 8'hA5, 1'b1, 3'd0, 1'b0);
    tick();
    check_eq("hold_stable", 32'(bus.dout), 32'hA5);
    consume_one();
    check_eq("basic_consumed", 32'(bus.dout_valid), 32'd0);
    consume_one();
    check_eq("ready_when_empty", 32'(bus.dout_valid), 32'd0);

    // Gapped capture after a fresh reset.
    Re = 1'b0;
    tick();
    Re = 1'b1;
    shift_word(8'hA5, 1'b1, 1'b1, 1'b0);
    check_state("gapped", 8'hA5, 1'b1, 3'd0, 1'b0);
    consume_one();

    // Back-to-back with ready on the completion cycle of the second word.
    shift_word(8'h3C, 1'b0, 1'b1, 1'b0);
    check_state("b2b_first", 8'h3C, 1'b1, 3'd0, 1'b0);
    shift_word(8'hC3, 1'b0, 1'b1, 1'b1);
    check_state("b2b_second", 8'hC3, 1'b1, 3'd0, 1'b0);
    consume_one();
    check_eq("b2b_drained", 32'(bus.dout_valid), 32'd0);

    // Overrun: second word dropped, flag sticky across a consume.
    shift_word(8'h11, 1'b0, 1'b1, 1'b0);
    shift_word(8'h22, 1'b0, 1'b0, 1'b0);
    check_state("overrun", 8'h11, 1'b1, 3'd0, 1'b1);
    consume_one();
    check_eq("ovr_consumed_valid", 32'(bus.dout_valid), 32'd0);
    check_eq("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Clear mid-word; shift_en and ready are ignored during the clear cycle.
    for (int i = 0; i < 5; i++) begin
      bus.din      = 1'b1;
      bus.shift_en = 1'b1;
      tick();
    end
    check_eq("partial_cnt", 32'(bus.bit_cnt), 32'd5);
    inz            = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    inz            = 1'b0;
    bus.shift_en   = 1'b0;
    bus.dout_ready = 1'b0;
    check_state("clear", 8'h00, 1'b0, 3'd0, 1'b0);
    shift_word(8'hF0, 1'b0, 1'b1, 1'b0);
    check_state("after_clear", 8'hF0, 1'b1, 3'd0, 1'b0);

    // Reset and clear together while FULL.
    Re  = 1'b0;
    inz = 1'b1;
    tick();
    Re  = 1'b1;
    inz = 1'b0;
    check_state("rst_prio", 8'h00, 1'b0, 3'd0, 1'b0);
    bus.din      = 1'b1;
    bus.shift_en = 1'b1;
    tick();
    bus.shift_en = 1'b0;
    check_eq("first_bit_cnt", 32'(bus.bit_cnt), 32'd1);
    Re = 1'b0;
    tick();
    Re = 1'b1;

    // An Re pulse between edges must not disturb a held word.
    shift_word(8'h5A, 1'b0, 1'b1, 1'b0);
    Re = 1'b0;
    #3;
    Re = 1'b1;
    tick();
    check_state("re_glitch", 8'h5A, 1'b1, 3'd0, 1'b0);
    consume_one();
    tick();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
